// File: rtl/keypad_pkg.sv
// Shared keypad geometry, key codes (bit = row*4+col) and the single-key check
// used by the scanner and the downstream encoder.
package keypad_pkg;

  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;
  localparam int unsigned KEY_W    = KEY_ROWS * KEY_COLS;

  localparam logic [15:0] KEY_NONE  = 16'h0000;
  localparam logic [15:0] KEY_ENTER = 16'h0001;
  localparam logic [15:0] KEY_0     = 16'h0002;
  localparam logic [15:0] KEY_1     = 16'h0004;
  localparam logic [15:0] KEY_2     = 16'h0008;
  localparam logic [15:0] KEY_3     = 16'h0010;
  localparam logic [15:0] KEY_4     = 16'h0020;
  localparam logic [15:0] KEY_5     = 16'h0040;
  localparam logic [15:0] KEY_6     = 16'h0080;
  localparam logic [15:0] KEY_CLEAR = 16'h0100;
  localparam logic [15:0] KEY_7     = 16'h0200;
  localparam logic [15:0] KEY_8     = 16'h0400;
  localparam logic [15:0] KEY_9     = 16'h0800;
  localparam logic [15:0] KEY_BACK  = 16'h1000;
  localparam logic [15:0] KEY_A     = 16'h2000;
  localparam logic [15:0] KEY_B     = 16'h4000;
  localparam logic [15:0] KEY_C     = 16'h8000;

  // True when no more than one bit of the frame is set.
  function automatic logic at_most_one(input logic [15:0] f);
    return (f & (f - 16'd1)) == 16'h0000;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_frame_debouncer.sv
// Debounces whole-keypad frames: multi-key frames count as empty, and onehot
// only moves after DEBOUNCE_FRAMES identical qualified frames.
module frame_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [15:0] frame,
  input  logic        frame_done,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [15:0]      qual;
  logic [15:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    qual     = at_most_one(frame) ? frame : KEY_NONE;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    pulse_d  = 1'b0;
    if (frame_done) begin
      if (qual == cand_q) begin
        if (cnt_q != STABLE) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = qual;
        cnt_d  = '0;
      end
    end
    // Candidate has been seen DEBOUNCE_FRAMES times in a row: publish it.
    if ((cnt_q == STABLE) && (cand_q != onehot_q)) begin
      onehot_d = cand_q;
      valid_d  = (cand_q != KEY_NONE);
      pulse_d  = (cand_q != KEY_NONE);
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cand_q   <= KEY_NONE;
      cnt_q    <= '0;
      onehot_q <= KEY_NONE;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
    end
  end

  assign onehot    = onehot_q;
  assign key_valid = valid_q;
  assign key_pulse = pulse_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchroniser and frame
// assembly, feeding a frame debouncer that presents a single-key onehot code.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [15:0]      raw_q, raw_d;
  logic             frame_done_q, frame_done_d;

  // Rows are sampled only at terminal count so the column has settled.
  always_comb begin
    sync1_d      = row_in;
    sync2_d      = sync1_q;
    div_d        = div_q + DIV_W'(1);
    col_idx_d    = col_idx_q;
    col_out_d    = col_out_q;
    raw_d        = raw_q;
    frame_done_d = 1'b0;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      for (int r = 0; r < KEY_ROWS; r++) begin
        raw_d[r*KEY_COLS + 32'(col_idx_q)] = ~sync2_q[r];
      end
      col_idx_d    = col_idx_q + 2'd1;
      col_out_d    = ~(4'b0001 << col_idx_d);
      frame_done_d = (col_idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      col_out_q    <= 4'b1110;
      raw_q        <= KEY_NONE;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      col_out_q    <= col_out_d;
      raw_q        <= raw_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign col_out = col_out_q;

  frame_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debouncer (
    .clk        (clk),
    .RSTn       (RSTn),
    .frame      (raw_q),
    .frame_done (frame_done_q),
    .onehot     (onehot),
    .key_valid  (key_valid),
    .key_pulse  (key_pulse)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Keypad scanner bench: a keypad model drives row_in from col_out; expected
// onehot changes are queued with a deadline and checked by a monitor.
module tb_keypad_matrix_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int          FRAME    = 16;
  localparam int          LAT      = 4 * FRAME + 1;

  logic        clk;
  logic        RSTn;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;

  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          failures;
  int          stray;

  typedef struct {
    logic [15:0] val;
    int          deadline;
  } exp_t;
  exp_t q[$];

  keypad_matrix_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .row_in    (row_in),
    .col_out   (col_out),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive keypad: a closed switch pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_keys(input logic [15:0] k, input bit expect_change);
    exp_t e;
    @(posedge clk);
    #1;
    keys = k;
    if (expect_change) begin
      e.val = k;
      e.deadline = cyc + LAT;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0 (cycle %0d)", q.size(), cyc);
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] prev;
    exp_t        e;
    logic [3:0]  ecol;
    checks = 0; failures = 0; stray = 0; cyc = 0;
    keys = 16'h0000;
    RSTn = 1'b0;
    prev = 16'h0000;

    fork
      forever begin
        @(negedge clk);
        if (!RSTn) begin
          prev = 16'h0000;
        end else if (onehot !== prev) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_change actual=%h required=%h (cycle %0d)", onehot, prev, cyc);
          end else begin
            e = q.pop_front();
            check("onehot_value", onehot, e.val);
            check("key_valid_on_change", 16'(key_valid), 16'(e.val != 16'h0000));
            check("key_pulse_on_change", 16'(key_pulse), 16'(e.val != 16'h0000));
            checks++;
            if (cyc > e.deadline) begin
              failures++;
              $display("FAIL latency actual_cycle=%0d required_by=%0d", cyc, e.deadline);
            end
          end
          prev = onehot;
        end else begin
          if (key_pulse !== 1'b0) stray++;
          if (key_valid !== (prev != 16'h0000)) stray++;
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_col_out", 16'(col_out), 16'h000E);
    check("reset_onehot", onehot, 16'h0000);
    check("reset_key_valid", 16'(key_valid), 16'h0000);
    check("reset_key_pulse", 16'(key_pulse), 16'h0000);
    @(negedge clk);
    RSTn = 1'b1;

    // 1: column rotation, 4 cycles per column
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      ecol = ~(4'b0001 << (((k + 1) / 4) % 4));
      check("col_rotation", 16'(col_out), 16'(ecol));
    end
    repeat (2 * FRAME) @(posedge clk);

    // 2: clean press row1/col2, then release
    set_keys(16'h0040, 1'b1);
    wait_drain(200);
    set_keys(16'h0000, 1'b1);
    wait_drain(200);

    // 3: bouncing row2/col0 for two frames, then steady
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      keys = (((i / 5) % 2) == 0) ? 16'h0100 : 16'h0000;
    end
    set_keys(16'h0100, 1'b1);
    wait_drain(200);
    set_keys(16'h0000, 1'b1);
    wait_drain(200);

    // 4: hold then release; release must not pulse
    set_keys(16'h0008, 1'b1);
    wait_drain(200);
    set_keys(16'h0000, 1'b1);
    wait_drain(200);

    // 5: two keys together are rejected
    set_keys(16'h8001, 1'b0);
    repeat (8 * FRAME) @(posedge clk);
    #1;
    check("multikey_rejected", onehot, 16'h0000);
    set_keys(16'h0000, 1'b0);
    repeat (4 * FRAME) @(posedge clk);

    // 6: reset mid-frame while a key is shown, key still held afterwards
    set_keys(16'h8000, 1'b1);
    wait_drain(200);
    repeat (5) @(posedge clk);
    #3;
    RSTn = 1'b0;
    #1;
    check("midreset_onehot", onehot, 16'h0000);
    check("midreset_col_out", 16'(col_out), 16'h000E);
    check("midreset_key_valid", 16'(key_valid), 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RSTn = 1'b1;
    e.val = 16'h8000;
    e.deadline = cyc + LAT;
    q.push_back(e);
    wait_drain(200);
    set_keys(16'h0000, 1'b1);
    wait_drain(200);
    repeat (FRAME) @(posedge clk);

    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL stray_pulse_or_valid actual=%0d required=0", stray);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Scans a 4x4 active-low matrix keypad, debounces whole-keypad snapshots and presents a single-key one-hot code, held for as long as the key is pressed. Sits directly upstream of the key-to-digit encoder/password stage, which consumes onehot as a level (16'h0000 = no key). Rejects multi-key presses so the downstream stage only ever sees one-hot or zero.

Parameters:
SCAN_DIV, 50000, clk cycles each column is driven (1 ms at 50 MHz); must be >= 4
DEBOUNCE_FRAMES, 4, consecutive identical full-keypad frames required before onehot changes; must be >= 2

Ports:
clk  input  1  system clock, 50 MHz
RSTn  input  1  asynchronous active-low reset
row_in  input  4  keypad rows, active low, externally pulled up
col_out  output  4  column drive, active low, exactly one bit low at all times
onehot  output  16  debounced key code, bit (row*4+col); 0 = no key
key_valid  output  1  high while onehot != 0
key_pulse  output  1  one-cycle strobe when onehot changes to a nonzero value

Behaviour:
- Reset, clk and RSTn: RSTn is asynchronous, active-low; clock is clk. Reset values: col_out=4'b1110, onehot=0, key_valid=0, key_pulse=0, column index=0, divider=0, candidate=0, stable count=0, sync flops=4'b1111.
- row_in passes through a 2-flop synchroniser before use.
- Divider counts 0..SCAN_DIV-1. On terminal count (div==SCAN_DIV-1): sample synced rows into a 4-bit slot for the current column, then advance column index (3 wraps to 0) and drive col_out=~(1<<next). Sampling only at terminal count gives SCAN_DIV-1 cycles of settle plus sync latency.
- Frame assembly: the sample taken at column c sets raw[r*4+c] = ~row_sync[r]. After column 3 is sampled, the frame is complete (frame_done, one cycle), every 4*SCAN_DIV cycles.
- Frame qualification: if popcount(raw) > 1, the frame is treated as 16'h0000 (ghosting/multi-key rejection).
- Debounce, evaluated on frame_done:
  - If qualified frame == candidate: stable count increments, saturating at DEBOUNCE_FRAMES-1.
  - Otherwise: candidate <= frame and stable count <= 0.
  - When stable count reaches DEBOUNCE_FRAMES-1 (i.e. DEBOUNCE_FRAMES equal frames) and candidate != onehot, load onehot <= candidate in the following cycle.
- key_valid is a registered copy of (onehot != 0), updated in the same cycle as onehot.
- key_pulse is high for exactly the one cycle in which onehot is loaded with a nonzero value. Key-to-key transitions with no intermediate release also pulse. Release (load of 0) does not pulse.
- Latency: a clean press is reflected on onehot within DEBOUNCE_FRAMES+1 frames plus 1 cycle. Release uses the same latency.
- Bounce: any frame differing from the candidate restarts the count. onehot holds its old value until stability is reached.
- Reset asserted mid-scan: all state returns to reset values immediately. Scanning restarts at column 0 after release.

Decomposition:
- Shared package (keypad_pkg): KEY_NONE=16'h0000; named one-hot constants for the 16 key positions (matching the encoder's codes, e.g. KEY_ENTER=16'h0001, KEY_CLEAR=16'h0100, KEY_BACK=16'h1000, digit keys); KEY_ROWS=4, KEY_COLS=4.
- One sub-module is natural: frame_debouncer. It takes a 16-bit frame plus a frame_done strobe and produces onehot, key_valid and key_pulse. It holds the candidate, stable counter and popcount rejection. The top level keeps the divider, column driver, synchroniser and frame assembly.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 cycles) for all scenarios.
1. Reset, no key: col_out cycles 1110 -> 1101 -> 1011 -> 0111 every 4 cycles; onehot stays 0; key_pulse never asserts.
2. Keypad model closes row1/col2, held steady -> onehot=16'h0040 within 4 frames plus 1 cycle; key_pulse high for exactly 1 cycle; key_valid=1.
3. Press row2/col0 bouncing (toggle every 5 cycles for 2 frames, then steady) -> onehot stays 0 during the bounce, then becomes 16'h0100 exactly 3 stable frames after the bounce ends; one key_pulse.
4. Hold 16'h0008, then release -> onehot returns to 0 after 3 stable empty frames; no key_pulse on release; key_valid falls with onehot.
5. Press row0/col0 and row3/col3 together -> frames are rejected; onehot stays at its prior value 0.
6. Assert RSTn low mid-frame while 16'h8000 is displayed -> onehot=0 and col_out=1110 immediately; after release with the key still held, 16'h8000 reappears with a fresh key_pulse.
